// File: rtl/drc_frame_capture_fsm.sv
// drc_frame_capture_fsm
// DVP receive capture controller. Takes {vsync,hsync,data} bytes from the
// pixel-info FIFO and forwards them to the DMA byte stream. Features:
// runtime bytes-per-pixel, stream-mode frame decimation, a stall watchdog,
// an exact last-byte flag and a saturating frame-error counter. When an error
// occurs, the remainder of the frame is padded with zero bytes. This
// guarantees that the DMA always receives a full frame's worth of bytes.
module drc_frame_capture_fsm #(
  parameter int DVP_DATA_W  = 8,
  parameter int BPP_MAX     = 4,
  parameter int IMG_DIM_MAX = 1280,
  parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX + 1),
  parameter int SKIP_W      = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int BPP_W      = (BPP_MAX > 1) ? $clog2(BPP_MAX) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // pixel-info FIFO side
  input  logic [DVP_DATA_W+1:0]   bwd_pxl_info_dat,
  input  logic                    bwd_pxl_info_vld,
  output logic                    bwd_pxl_info_rdy,
  // DMA byte stream side
  output logic [DVP_DATA_W-1:0]   fwd_hpxl_dat,
  output logic                    fwd_hpxl_last,
  output logic                    fwd_hpxl_vld,
  input  logic                    fwd_hpxl_rdy,
  // control / status
  input  logic                    cam_rx_en,
  input  logic [1:0]              cam_rx_mode,
  input  logic                    cam_rx_start,
  output logic                    cam_rx_start_qed,
  output logic [2:0]              cam_rx_state,
  output logic [2*IMG_DIM_W-1:0]  cam_rx_len,
  input  logic [BPP_W-1:0]        cfg_bpp,
  input  logic [SKIP_W-1:0]       cfg_frm_skip,
  input  logic [IMG_DIM_W-1:0]    img_width,
  input  logic [IMG_DIM_W-1:0]    img_height,
  input  logic                    irq_msk_frm_comp,
  input  logic                    irq_msk_frm_err,
  output logic                    irq,
  output logic                    trap,
  output logic [7:0]              err_cnt
);

  localparam int  LEN_W  = 2 * IMG_DIM_W;
  localparam int  TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit  TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    ST_SLEEP   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [BPP_W-1:0]       b_cnt_r;
  logic [IMG_DIM_W-1:0]   w_cnt_r;
  logic [IMG_DIM_W-1:0]   h_cnt_r;
  logic [LEN_W-1:0]       pxl_cnt_r;
  logic [SKIP_W-1:0]      skip_left_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic [7:0]             err_cnt_r;
  logic                   irq_r;
  logic                   trap_r;
  logic                   start_qed_r;

  // ---------------------------------------------------------------------
  // Decoded input fields and position flags
  // ---------------------------------------------------------------------
  logic                   vsync_s;
  logic                   hsync_s;
  logic [DVP_DATA_W-1:0]  data_s;
  logic                   b_last_s;
  logic                   w_last_s;
  logic                   h_last_s;
  logic                   frame_end_s;
  logic                   line_start_s;
  logic                   mismatch_s;
  logic                   mode_ok_s;
  logic                   go_s;
  logic                   tmo_hit_s;

  // ---------------------------------------------------------------------
  // Control strobes from the next-state logic
  // ---------------------------------------------------------------------
  logic                   bwd_rdy_s;
  logic                   fwd_vld_s;
  logic [DVP_DATA_W-1:0]  fwd_dat_s;
  logic                   fwd_last_s;
  logic                   adv_s;
  logic                   clr_cnt_s;
  logic                   tmo_clr_s;
  logic                   tmo_inc_s;
  logic                   skip_load_s;
  logic [SKIP_W-1:0]      skip_val_s;
  logic                   skip_dec_s;
  logic                   irq_nxt_s;
  logic                   trap_nxt_s;
  logic                   qed_nxt_s;
  logic                   err_inc_s;
  logic                   err_clr_s;

  assign vsync_s      = bwd_pxl_info_dat[DVP_DATA_W+1];
  assign hsync_s      = bwd_pxl_info_dat[DVP_DATA_W];
  assign data_s       = bwd_pxl_info_dat[DVP_DATA_W-1:0];

  assign b_last_s     = (b_cnt_r == cfg_bpp);
  assign w_last_s     = (w_cnt_r == (img_width  - IMG_DIM_W'(1)));
  assign h_last_s     = (h_cnt_r == (img_height - IMG_DIM_W'(1)));
  assign frame_end_s  = b_last_s & w_last_s & h_last_s;

  // hsync is expected exactly on the first byte of every line
  assign line_start_s = (w_cnt_r == IMG_DIM_W'(0)) && (b_cnt_r == BPP_W'(0));
  assign mismatch_s   = (hsync_s != line_start_s);

  assign mode_ok_s    = (cam_rx_mode == 2'd1) || (cam_rx_mode == 2'd2);
  assign go_s         = cam_rx_en & cam_rx_start & mode_ok_s;

  // Hit when the current idle cycle is the TIMEOUT_CYC-th in a row
  assign tmo_hit_s    = TMO_EN && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Next-state, handshake steering and event strobes
  always_comb begin
    state_nxt_s = state_r;
    bwd_rdy_s   = 1'b0;
    fwd_vld_s   = 1'b0;
    fwd_dat_s   = {DVP_DATA_W{1'b0}};
    fwd_last_s  = 1'b0;
    adv_s       = 1'b0;
    clr_cnt_s   = 1'b0;
    tmo_clr_s   = 1'b0;
    tmo_inc_s   = 1'b0;
    skip_load_s = 1'b0;
    skip_val_s  = {SKIP_W{1'b0}};
    skip_dec_s  = 1'b0;
    irq_nxt_s   = 1'b0;
    trap_nxt_s  = 1'b0;
    qed_nxt_s   = 1'b0;
    err_inc_s   = 1'b0;
    err_clr_s   = 1'b0;

    case (state_r)
      ST_SLEEP: begin
        // Drain the FIFO while asleep so stale bytes never reach a frame
        bwd_rdy_s = 1'b1;
        if (!cam_rx_en) begin
          err_clr_s = 1'b1;
        end else begin
          err_clr_s = 1'b0;
        end
        if (go_s) begin
          state_nxt_s = ST_ALIGN;
          skip_load_s = 1'b1;
          skip_val_s  = {SKIP_W{1'b0}};
          qed_nxt_s   = (cam_rx_mode == 2'd1);
        end else begin
          state_nxt_s = ST_SLEEP;
        end
      end

      ST_IDLE: begin
        // One-cycle decision point after a clean frame
        if (go_s) begin
          state_nxt_s = ST_ALIGN;
          skip_load_s = 1'b1;
          skip_val_s  = (cam_rx_mode == 2'd2) ? cfg_frm_skip : {SKIP_W{1'b0}};
          qed_nxt_s   = (cam_rx_mode == 2'd1);
        end else begin
          state_nxt_s = ST_SLEEP;
        end
      end

      ST_ALIGN: begin
        if (!cam_rx_en) begin
          state_nxt_s = ST_SLEEP;
          bwd_rdy_s   = 1'b1;
        end else if (bwd_pxl_info_vld && vsync_s) begin
          if (skip_left_r == {SKIP_W{1'b0}}) begin
            // Leave the vsync byte in the FIFO; CAPTURE forwards it
            state_nxt_s = ST_CAPTURE;
            clr_cnt_s   = 1'b1;
            bwd_rdy_s   = 1'b0;
          end else begin
            // Drop this frame's start; the rest is discarded below
            bwd_rdy_s   = 1'b1;
            skip_dec_s  = 1'b1;
          end
        end else begin
          bwd_rdy_s = 1'b1;
        end
      end

      ST_CAPTURE: begin
        fwd_vld_s  = bwd_pxl_info_vld;
        bwd_rdy_s  = fwd_hpxl_rdy;
        fwd_last_s = frame_end_s;
        // A misaligned byte is the first padded byte of the frame
        fwd_dat_s  = mismatch_s ? {DVP_DATA_W{1'b0}} : data_s;
        if (bwd_pxl_info_vld && fwd_hpxl_rdy) begin
          adv_s     = 1'b1;
          tmo_clr_s = 1'b1;
          if (mismatch_s) begin
            trap_nxt_s  = irq_msk_frm_err;
            err_inc_s   = 1'b1;
            state_nxt_s = frame_end_s ? ST_ALIGN : ST_FLUSH;
          end else if (frame_end_s) begin
            irq_nxt_s   = irq_msk_frm_comp;
            state_nxt_s = ST_IDLE;
          end else if (!cam_rx_en) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end else if (!cam_rx_en) begin
          state_nxt_s = ST_FLUSH;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_FLUSH;
          trap_nxt_s  = irq_msk_frm_err;
          err_inc_s   = 1'b1;
        end else begin
          tmo_inc_s = 1'b1;
        end
      end

      ST_FLUSH: begin
        // Zero padding up to the frame's last byte; source bytes are discarded
        bwd_rdy_s  = 1'b1;
        fwd_vld_s  = 1'b1;
        fwd_dat_s  = {DVP_DATA_W{1'b0}};
        fwd_last_s = frame_end_s;
        if (fwd_hpxl_rdy) begin
          adv_s       = 1'b1;
          state_nxt_s = frame_end_s ? ST_ALIGN : ST_FLUSH;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end

      default: begin
        state_nxt_s = ST_SLEEP;
        bwd_rdy_s   = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SLEEP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Byte / column / line / pixel position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt_r   <= {BPP_W{1'b0}};
      w_cnt_r   <= {IMG_DIM_W{1'b0}};
      h_cnt_r   <= {IMG_DIM_W{1'b0}};
      pxl_cnt_r <= {LEN_W{1'b0}};
    end else if (clr_cnt_s) begin
      b_cnt_r   <= {BPP_W{1'b0}};
      w_cnt_r   <= {IMG_DIM_W{1'b0}};
      h_cnt_r   <= {IMG_DIM_W{1'b0}};
      pxl_cnt_r <= {LEN_W{1'b0}};
    end else if (adv_s) begin
      if (b_last_s) begin
        b_cnt_r   <= {BPP_W{1'b0}};
        pxl_cnt_r <= pxl_cnt_r + LEN_W'(1);
        if (w_last_s) begin
          w_cnt_r <= {IMG_DIM_W{1'b0}};
          h_cnt_r <= h_last_s ? {IMG_DIM_W{1'b0}} : (h_cnt_r + IMG_DIM_W'(1));
        end else begin
          w_cnt_r <= w_cnt_r + IMG_DIM_W'(1);
        end
      end else begin
        b_cnt_r <= b_cnt_r + BPP_W'(1);
      end
    end else begin
      pxl_cnt_r <= pxl_cnt_r;
    end
  end

  // Stall watchdog: counts consecutive CAPTURE cycles without a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (clr_cnt_s || tmo_clr_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (tmo_inc_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Frames still to drop before the next capture in stream mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_left_r <= {SKIP_W{1'b0}};
    end else if (skip_load_s) begin
      skip_left_r <= skip_val_s;
    end else if (skip_dec_s) begin
      skip_left_r <= skip_left_r - SKIP_W'(1);
    end else begin
      skip_left_r <= skip_left_r;
    end
  end

  // Saturating frame-error counter, cleared only while disabled and asleep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (err_clr_s) begin
      err_cnt_r <= 8'd0;
    end else if (err_inc_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  // One-cycle event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r       <= 1'b0;
      trap_r      <= 1'b0;
      start_qed_r <= 1'b0;
    end else begin
      irq_r       <= irq_nxt_s;
      trap_r      <= trap_nxt_s;
      start_qed_r <= qed_nxt_s;
    end
  end

  // The byte path is a zero-latency pass-through, so its controls stay combinational
  assign bwd_pxl_info_rdy = bwd_rdy_s;
  assign fwd_hpxl_vld     = fwd_vld_s;
  assign fwd_hpxl_dat     = fwd_dat_s;
  assign fwd_hpxl_last    = fwd_last_s;

  assign cam_rx_state     = state_r;
  assign cam_rx_len       = pxl_cnt_r;
  assign cam_rx_start_qed = start_qed_r;
  assign irq              = irq_r;
  assign trap             = trap_r;
  assign err_cnt          = err_cnt_r;

endmodule

// File: tb/tb_drc_frame_capture_fsm.sv
// Self-checking bench for drc_frame_capture_fsm. Frames are built into a
// source queue; the bytes the DMA should see are pushed to a scoreboard at
// the same time and compared, in order, on every forward handshake.
`timescale 1ns/1ps
module tb_drc_frame_capture_fsm;

  localparam int DW     = 8;
  localparam int DIM_W  = 11;
  localparam int SKIP_W = 4;
  localparam int TMO    = 16;

  localparam logic [2:0] S_SLEEP = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DW+1:0]      bwd_dat;
  logic               bwd_vld;
  logic               bwd_rdy;
  logic [DW-1:0]      fwd_dat;
  logic               fwd_last;
  logic               fwd_vld;
  logic               fwd_rdy;
  logic               en;
  logic [1:0]         mode;
  logic               start;
  logic               start_qed;
  logic [2:0]         state;
  logic [2*DIM_W-1:0] len;
  logic [1:0]         bpp;
  logic [SKIP_W-1:0]  skip;
  logic [DIM_W-1:0]   width;
  logic [DIM_W-1:0]   height;
  logic               msk_comp;
  logic               msk_err;
  logic               irq;
  logic               trap;
  logic [7:0]         err_cnt;

  // bit 10 set marks one idle (vld=0) source cycle
  logic [10:0] src_q[$];
  // {last, data} expected at the DMA port
  logic [8:0]  exp_q[$];

  int    errors = 0;
  int    checks = 0;
  int    irq_seen, trap_seen, qed_seen, fwd_cnt, zero_run;
  bit    rnd_rdy;
  string cur_test;

  always #5 clk = ~clk;

  drc_frame_capture_fsm #(.TIMEOUT_CYC(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bwd_pxl_info_dat (bwd_dat),
    .bwd_pxl_info_vld (bwd_vld),
    .bwd_pxl_info_rdy (bwd_rdy),
    .fwd_hpxl_dat     (fwd_dat),
    .fwd_hpxl_last    (fwd_last),
    .fwd_hpxl_vld     (fwd_vld),
    .fwd_hpxl_rdy     (fwd_rdy),
    .cam_rx_en        (en),
    .cam_rx_mode      (mode),
    .cam_rx_start     (start),
    .cam_rx_start_qed (start_qed),
    .cam_rx_state     (state),
    .cam_rx_len       (len),
    .cfg_bpp          (bpp),
    .cfg_frm_skip     (skip),
    .img_width        (width),
    .img_height       (height),
    .irq_msk_frm_comp (msk_comp),
    .irq_msk_frm_err  (msk_err),
    .irq              (irq),
    .trap             (trap),
    .err_cnt          (err_cnt)
  );

  // One clock: drive at posedge+1, sample at the falling edge, return at posedge+1
  task automatic step();
    logic [8:0] e;
    bit         marker;
    marker = 1'b0;
    if (src_q.size() > 0 && src_q[0][10]) begin
      marker  = 1'b1;
      bwd_vld = 1'b0;
      bwd_dat = '0;
    end else if (src_q.size() > 0) begin
      bwd_vld = 1'b1;
      bwd_dat = src_q[0][9:0];
    end else begin
      bwd_vld = 1'b0;
      bwd_dat = '0;
    end
    if (rnd_rdy) begin
      if (zero_run >= 3) fwd_rdy = 1'b1;
      else fwd_rdy = 1'($urandom_range(0, 1));
      zero_run = fwd_rdy ? 0 : zero_run + 1;
    end else begin
      fwd_rdy = 1'b1;
    end
    #4;
    if (irq)       irq_seen++;
    if (trap)      trap_seen++;
    if (start_qed) qed_seen++;
    if (fwd_vld && fwd_rdy) begin
      fwd_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s extra_byte: got last=%b dat=%h, expected no byte", cur_test, fwd_last, fwd_dat);
      end else begin
        e = exp_q.pop_front();
        if ({fwd_last, fwd_dat} !== e) begin
          errors++;
          $display("FAIL %s byte%0d: got last=%b dat=%h, expected last=%b dat=%h",
                   cur_test, fwd_cnt, fwd_last, fwd_dat, e[8], e[7:0]);
        end
      end
    end
    if (marker) void'(src_q.pop_front());
    else if (bwd_vld && bwd_rdy) void'(src_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    irq_seen = 0; trap_seen = 0; qed_seen = 0; fwd_cnt = 0; zero_run = 0;
  endtask

  task automatic start_capture(input logic [1:0] m);
    mode  = m;
    en    = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10 && state != S_ALIGN; i++) step();
    checks++;
    if (state !== S_ALIGN) begin
      errors++;
      $display("FAIL %s start: state=%0d expected %0d", cur_test, state, S_ALIGN);
    end
    if (m == 2'd1) start = 1'b0;
  endtask

  task automatic go_sleep();
    en    = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 100 && state != S_SLEEP; i++) step();
    step();
    checks++;
    if (state !== S_SLEEP) begin
      errors++;
      $display("FAIL %s sleep: state=%0d expected %0d", cur_test, state, S_SLEEP);
    end
  endtask

  task automatic run_until_empty(input int max_cyc);
    for (int i = 0; i < max_cyc && (src_q.size() > 0 || exp_q.size() > 0); i++) step();
    checks++;
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: src_left=%0d exp_left=%0d, expected 0 and 0", cur_test, src_q.size(), exp_q.size());
      src_q.delete();
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  // Queue one frame; err_byte flips hsync of that byte, a stall of TMO or more trips the watchdog
  task automatic build_frame(input int bpp_v, input int w, input int h, input logic [7:0] base,
                             input int err_byte, input int stall_after, input int stall_len, input bit fwd);
    int         k;
    int         total;
    logic       vs, hs, zeroed;
    logic [7:0] d;
    total = (bpp_v + 1) * w * h;
    k = 0;
    for (int hh = 0; hh < h; hh++)
      for (int ww = 0; ww < w; ww++)
        for (int bb = 0; bb <= bpp_v; bb++) begin
          k++;
          vs = (k == 1);
          hs = (ww == 0 && bb == 0);
          if (k == err_byte) hs = ~hs;
          d = base + 8'(k);
          src_q.push_back({1'b0, vs, hs, d});
          zeroed = (err_byte != 0 && k >= err_byte) ||
                   (stall_after != 0 && stall_len >= TMO && k > stall_after);
          if (fwd) exp_q.push_back({(k == total), zeroed ? 8'h00 : d});
          if (k == stall_after)
            for (int s = 0; s < stall_len; s++) src_q.push_back(11'h400);
        end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== S_SLEEP || bwd_rdy !== 1'b1 || fwd_vld !== 1'b0 || fwd_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d rdy=%b vld=%b last=%b, expected 0 1 0 0", state, bwd_rdy, fwd_vld, fwd_last);
    end
    checks++;
    if (irq !== 1'b0 || trap !== 1'b0 || start_qed !== 1'b0 || err_cnt !== 8'd0 || len !== '0 || fwd_dat !== 8'd0) begin
      errors++;
      $display("FAIL reset_stat: irq=%b trap=%b qed=%b err=%0d len=%0d dat=%h, expected all 0",
               irq, trap, start_qed, err_cnt, len, fwd_dat);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (state !== S_SLEEP) begin
      errors++;
      $display("FAIL reset_hold: state=%0d expected 0", state);
    end
  endtask

  task automatic test_clean_frame();
    cur_test = "clean"; clear_stats();
    bpp = 2'd1; width = 11'd4; height = 11'd2; rnd_rdy = 1'b0;
    start_capture(2'd1);
    build_frame(1, 4, 2, 8'h10, 0, 0, 0, 1'b1);
    run_until_empty(200);
    checks++; if (fwd_cnt !== 16) begin errors++; $display("FAIL clean_count: got %0d expected 16", fwd_cnt); end
    checks++; if (irq_seen !== 1) begin errors++; $display("FAIL clean_irq: got %0d expected 1", irq_seen); end
    checks++; if (trap_seen !== 0) begin errors++; $display("FAIL clean_trap: got %0d expected 0", trap_seen); end
    checks++; if (qed_seen !== 1) begin errors++; $display("FAIL clean_qed: got %0d expected 1", qed_seen); end
    checks++; if (len !== 22'd8) begin errors++; $display("FAIL clean_len: got %0d expected 8", len); end
    checks++; if (state !== S_SLEEP) begin errors++; $display("FAIL clean_state: got %0d expected 0", state); end
  endtask

  task automatic test_hsync_error();
    cur_test = "hsync_err"; clear_stats();
    start_capture(2'd1);
    build_frame(1, 4, 2, 8'h30, 9, 0, 0, 1'b1);
    run_until_empty(200);
    checks++; if (fwd_cnt !== 16) begin errors++; $display("FAIL herr_count: got %0d expected 16", fwd_cnt); end
    checks++; if (trap_seen !== 1) begin errors++; $display("FAIL herr_trap: got %0d expected 1", trap_seen); end
    checks++; if (irq_seen !== 0) begin errors++; $display("FAIL herr_irq: got %0d expected 0", irq_seen); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL herr_errcnt: got %0d expected 1", err_cnt); end
    checks++; if (state !== S_ALIGN) begin errors++; $display("FAIL herr_state: got %0d expected 2", state); end
    go_sleep();
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL herr_clear: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_stream_skip();
    cur_test = "stream"; clear_stats();
    bpp = 2'd0; width = 11'd2; height = 11'd2; skip = 4'd2;
    start_capture(2'd2);
    build_frame(0, 2, 2, 8'h40, 0, 0, 0, 1'b1);
    build_frame(0, 2, 2, 8'h50, 0, 0, 0, 1'b0);
    build_frame(0, 2, 2, 8'h60, 0, 0, 0, 1'b0);
    build_frame(0, 2, 2, 8'h70, 0, 0, 0, 1'b1);
    run_until_empty(200);
    checks++; if (fwd_cnt !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", fwd_cnt); end
    checks++; if (irq_seen !== 2) begin errors++; $display("FAIL stream_irq: got %0d expected 2", irq_seen); end
    checks++; if (qed_seen !== 0) begin errors++; $display("FAIL stream_qed: got %0d expected 0", qed_seen); end
    checks++; if (state !== S_ALIGN) begin errors++; $display("FAIL stream_state: got %0d expected 2", state); end
    go_sleep();
  endtask

  task automatic test_timeout();
    cur_test = "tmo_short"; clear_stats();
    bpp = 2'd1; width = 11'd4; height = 11'd2;
    start_capture(2'd1);
    build_frame(1, 4, 2, 8'h80, 0, 5, TMO - 1, 1'b1);
    run_until_empty(300);
    checks++; if (trap_seen !== 0 || irq_seen !== 1) begin
      errors++; $display("FAIL tmo_short: trap=%0d irq=%0d expected 0 1", trap_seen, irq_seen); end
    cur_test = "tmo_trip"; clear_stats();
    start_capture(2'd1);
    build_frame(1, 4, 2, 8'h90, 0, 5, TMO, 1'b1);
    run_until_empty(300);
    checks++; if (trap_seen !== 1) begin errors++; $display("FAIL tmo_trap: got %0d expected 1", trap_seen); end
    checks++; if (fwd_cnt !== 16) begin errors++; $display("FAIL tmo_count: got %0d expected 16", fwd_cnt); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL tmo_errcnt: got %0d expected 1", err_cnt); end
    checks++; if (state !== S_ALIGN) begin errors++; $display("FAIL tmo_state: got %0d expected 2", state); end
    go_sleep();
  endtask

  task automatic test_random_ready();
    cur_test = "rnd_rdy"; clear_stats();
    bpp = 2'd3; width = 11'd3; height = 11'd3; rnd_rdy = 1'b1;
    start_capture(2'd1);
    build_frame(3, 3, 3, 8'hA0, 0, 0, 0, 1'b1);
    run_until_empty(500);
    rnd_rdy = 1'b0;
    checks++; if (fwd_cnt !== 36) begin errors++; $display("FAIL rnd_count: got %0d expected 36", fwd_cnt); end
    checks++; if (irq_seen !== 1) begin errors++; $display("FAIL rnd_irq: got %0d expected 1", irq_seen); end
    checks++; if (len !== 22'd9) begin errors++; $display("FAIL rnd_len: got %0d expected 9", len); end
  endtask

  task automatic test_en_drop();
    cur_test = "en_drop"; clear_stats();
    bpp = 2'd0; width = 11'd4; height = 11'd2;
    start_capture(2'd1);
    src_q.push_back({1'b0, 1'b1, 1'b1, 8'hC1}); exp_q.push_back({1'b0, 8'hC1});
    src_q.push_back({1'b0, 1'b0, 1'b0, 8'hC2}); exp_q.push_back({1'b0, 8'hC2});
    src_q.push_back({1'b0, 1'b0, 1'b0, 8'hC3}); exp_q.push_back({1'b0, 8'hC3});
    for (int i = 0; i < 20 && src_q.size() > 0; i++) step();
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'h00});
    en = 1'b0;
    run_until_empty(100);
    checks++; if (fwd_cnt !== 8) begin errors++; $display("FAIL endrop_count: got %0d expected 8", fwd_cnt); end
    checks++; if (trap_seen !== 0 || irq_seen !== 0) begin
      errors++; $display("FAIL endrop_evt: trap=%0d irq=%0d expected 0 0", trap_seen, irq_seen); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL endrop_errcnt: got %0d expected 0", err_cnt); end
    checks++; if (state !== S_SLEEP) begin errors++; $display("FAIL endrop_state: got %0d expected 0", state); end
  endtask

  task automatic test_err_saturation();
    cur_test = "err_sat"; clear_stats();
    bpp = 2'd0; width = 11'd1; height = 11'd1;
    start_capture(2'd1);
    for (int i = 0; i < 260; i++) begin
      src_q.push_back({1'b0, 1'b1, 1'b0, 8'hA5});
      exp_q.push_back({1'b1, 8'h00});
    end
    run_until_empty(2000);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_errcnt: got %0d expected 255", err_cnt); end
    checks++; if (trap_seen !== 260) begin errors++; $display("FAIL sat_trap: got %0d expected 260", trap_seen); end
    checks++; if (state !== S_ALIGN) begin errors++; $display("FAIL sat_state: got %0d expected 2", state); end
    go_sleep();
  endtask

  initial begin
    bwd_dat = '0; bwd_vld = 1'b0; fwd_rdy = 1'b1;
    en = 1'b0; mode = 2'd0; start = 1'b0;
    bpp = 2'd0; skip = '0; width = 11'd1; height = 11'd1;
    msk_comp = 1'b1; msk_err = 1'b1; rnd_rdy = 1'b0;
    clear_stats();
    test_reset();
    test_clean_frame();
    test_hsync_error();
    test_stream_skip();
    test_timeout();
    test_random_ready();
    test_en_drop();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
